// File: rtl/sdrc_responder_model.sv
// Behavioural-but-synthesizable SDRAM controller user-port responder backed by an internal word RAM.
// Emulates command timing and bank/row state, and flags initiator protocol misuse.
module sdrc_responder_model #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INIT_CYCLES = 16,
    parameter int ACT_LAT     = 1,
    parameter int READ_LAT    = 4,
    parameter int WRITE_REC   = 3,
    parameter int TRFC        = 9
) (
    input  logic        I_sdrc_clk,
    input  logic        I_sdrc_rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        O_proto_err
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACT, S_WR, S_RD, S_REF, S_PRE} state_e;

    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] init_cnt_q, init_cnt_d;
    logic [1:0]  bank_q, bank_d;
    logic [10:0] row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  len_q, len_d;
    logic        apre_q, apre_d;
    logic        hit_q, hit_d;
    logic [3:0]  open_q, open_d;
    logic [10:0] rows_q [4];
    logic [10:0] rows_d [4];
    logic        ack_q, ack_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem [DEPTH];

    logic                  done_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_idx_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;

    function automatic logic [ADDR_WIDTH-1:0] ram_index(input logic [1:0] b, input logic [10:0] r,
                                                        input logic [7:0] c);
        logic [20:0] full;
        full = {b, r, c};
        return full[ADDR_WIDTH-1:0];
    endfunction

    // cnt_q holds j before edge E+j, so each busy state finishes when it reaches its latency
    always_comb begin
        done_s = 1'b0;
        case (state_q)
            S_ACT:   done_s = (cnt_q == 16'(ACT_LAT));
            S_WR:    done_s = (cnt_q == {8'd0, len_q} + 16'(WRITE_REC));
            S_RD:    done_s = (cnt_q == {8'd0, len_q} + 16'(READ_LAT));
            S_REF:   done_s = (cnt_q == 16'(TRFC));
            S_PRE:   done_s = (cnt_q == 16'd1);
            default: done_s = 1'b0;
        endcase
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == 16'(INIT_CYCLES - 1)) state_d = S_IDLE;
                else                                    state_d = S_INIT;
            end
            S_IDLE: begin
                if (I_sdrc_cmd_en) begin
                    case (I_sdrc_cmd)
                        CMD_REF: state_d = S_REF;
                        CMD_PRE: state_d = S_PRE;
                        CMD_ACT: state_d = S_ACT;
                        CMD_WR:  state_d = S_WR;
                        CMD_RD:  state_d = S_RD;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACT, S_WR, S_RD, S_REF, S_PRE: begin
                if (done_s) state_d = S_IDLE;
                else        state_d = state_q;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Datapath, bank bookkeeping and RAM port control
    always_comb begin
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        len_d       = len_q;
        apre_d      = apre_q;
        hit_d       = hit_q;
        open_d      = open_q;
        rows_d      = rows_q;
        ack_d       = ack_q;
        err_d       = err_q;
        data_d      = data_q;
        wr_en_s     = 1'b0;
        wr_idx_s    = ram_index(bank_q, row_q, col_q + cnt_q[7:0]);
        rd_idx_s    = ram_index(bank_q, row_q, col_q + 8'(cnt_q - 16'(READ_LAT)));
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 16'd1;
                if (init_cnt_q == 16'(INIT_CYCLES - 1)) init_done_d = 1'b1;
                else                                    init_done_d = init_done_q;
            end
            S_IDLE: begin
                if (I_sdrc_cmd_en) begin
                    cnt_d  = 16'd1;
                    bank_d = I_sdrc_addr[20:19];
                    row_d  = rows_q[I_sdrc_addr[20:19]];
                    col_d  = I_sdrc_addr[7:0];
                    len_d  = I_sdrc_data_len;
                    apre_d = I_sdrc_precharge_ctrl;
                    hit_d  = open_q[I_sdrc_addr[20:19]];
                    case (I_sdrc_cmd)
                        CMD_REF: ack_d = 1'b0;
                        CMD_PRE: begin
                            ack_d  = 1'b0;
                            open_d = 4'b0000;
                        end
                        CMD_ACT: begin
                            ack_d = 1'b0;
                            if (open_q[I_sdrc_addr[20:19]]) err_d = 1'b1;
                            else                            err_d = err_q;
                            open_d[I_sdrc_addr[20:19]] = 1'b1;
                            rows_d[I_sdrc_addr[20:19]] = I_sdrc_addr[18:8];
                        end
                        CMD_WR, CMD_RD: begin
                            ack_d = 1'b0;
                            if (!open_q[I_sdrc_addr[20:19]]) err_d = 1'b1;
                            else                             err_d = err_q;
                            // word 0 of a write arrives with the strobe itself
                            wr_en_s  = (I_sdrc_cmd == CMD_WR) && open_q[I_sdrc_addr[20:19]];
                            wr_idx_s = ram_index(I_sdrc_addr[20:19], rows_q[I_sdrc_addr[20:19]],
                                                 I_sdrc_addr[7:0]);
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    ack_d = ack_q;
                end
            end
            S_ACT, S_WR, S_RD, S_REF, S_PRE: begin
                cnt_d = cnt_q + 16'd1;
                if (I_sdrc_cmd_en) err_d = 1'b1;
                else               err_d = err_q;
                if (state_q == S_WR && cnt_q <= {8'd0, len_q}) wr_en_s = hit_q;
                else                                           wr_en_s = 1'b0;
                if (state_q == S_RD && cnt_q >= 16'(READ_LAT)
                    && cnt_q <= 16'(READ_LAT) + {8'd0, len_q}) begin
                    data_d = hit_q ? mem[rd_idx_s] : 32'h0000_0000;
                end else begin
                    data_d = data_q;
                end
                if (done_s) begin
                    ack_d = 1'b1;
                    if (apre_q && (state_q == S_WR || state_q == S_RD)) open_d[bank_q] = 1'b0;
                    else                                                 open_d = open_q;
                end else begin
                    ack_d = ack_q;
                end
            end
            default: begin
                cnt_d = 16'd0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge I_sdrc_clk or negedge I_sdrc_rst_n) begin
        if (!I_sdrc_rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= 16'd0;
            init_cnt_q  <= 16'd0;
            bank_q      <= 2'd0;
            row_q       <= 11'd0;
            col_q       <= 8'd0;
            len_q       <= 8'd0;
            apre_q      <= 1'b0;
            hit_q       <= 1'b0;
            open_q      <= 4'b0000;
            for (int i = 0; i < 4; i++) rows_q[i] <= 11'd0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_cnt_q  <= init_cnt_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            len_q       <= len_d;
            apre_q      <= apre_d;
            hit_q       <= hit_d;
            open_q      <= open_d;
            for (int i = 0; i < 4; i++) rows_q[i] <= rows_d[i];
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            data_q      <= data_d;
        end
    end

    // Backing RAM with byte masking; contents deliberately survive reset
    always_ff @(posedge I_sdrc_clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) mem[wr_idx_s][b*8 +: 8] <= I_sdrc_data[b*8 +: 8];
            end
        end
    end

    assign O_sdrc_data      = data_q;
    assign O_sdrc_init_done = init_done_q;
    assign O_sdrc_cmd_ack   = ack_q;
    assign O_proto_err      = err_q;
endmodule

// File: tb/tb_sdrc_responder_model.sv
// Randomized self-checking bench for sdrc_responder_model against a word-level memory/bank model.
`timescale 1ns/1ps
module tb_sdrc_responder_model;
    localparam int INIT_CYCLES = 16, ACT_LAT = 1, READ_LAT = 4, WRITE_REC = 3, TRFC = 9;
    localparam logic [2:0] C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011, C_WR = 3'b100, C_RD = 3'b101;

    logic        clk = 1'b0, rst_n = 1'b0, cmd_en = 1'b0, pc = 1'b0;
    logic [2:0]  cmd = 3'b000;
    logic [20:0] addr = 21'd0;
    logic [3:0]  dqm = 4'd0;
    logic [31:0] wdat = 32'd0;
    logic [7:0]  dlen = 8'd0;
    logic [31:0] rdata;
    logic        init_done, ack, perr;

    always #5 clk = ~clk;

    sdrc_responder_model #(.ADDR_WIDTH(12), .INIT_CYCLES(INIT_CYCLES), .ACT_LAT(ACT_LAT),
                           .READ_LAT(READ_LAT), .WRITE_REC(WRITE_REC), .TRFC(TRFC)) dut (
        .I_sdrc_clk(clk), .I_sdrc_rst_n(rst_n), .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd),
        .I_sdrc_precharge_ctrl(pc), .I_sdrc_addr(addr), .I_sdrc_dqm(dqm), .I_sdrc_data(wdat),
        .I_sdrc_data_len(dlen), .O_sdrc_data(rdata), .O_sdrc_init_done(init_done),
        .O_sdrc_cmd_ack(ack), .O_proto_err(perr));

    int checks = 0, failures = 0;
    logic [31:0] wq [256];
    logic [3:0]  mq [256];
    logic [31:0] rq [$];
    int          lat;
    logic        ack_at_e;

    // reference model: flat word memory plus per-bank open flag and row
    logic [31:0] mem_m [4096];
    bit          known_m [4096];
    bit          open_m [4];
    int          row_m [4];
    bit          err_m;
    logic [31:0] exv [$];
    bit          exk [$];

    function automatic int midx(int b, int r, int c);
        return (b * 524288 + r * 256 + (c % 256)) % 4096;
    endfunction

    task automatic m_act(input logic [20:0] a);
        int b;
        b = int'(a[20:19]);
        if (open_m[b]) err_m = 1'b1;
        open_m[b] = 1'b1;
        row_m[b]  = int'(a[18:8]);
    endtask

    task automatic m_write(input logic [20:0] a, input int len, input logic p);
        int b, c, i;
        b = int'(a[20:19]);
        c = int'(a[7:0]);
        if (!open_m[b]) err_m = 1'b1;
        else begin
            for (int k = 0; k <= len; k++) begin
                i = midx(b, row_m[b], c + k);
                for (int y = 0; y < 4; y++)
                    if (!mq[k][y]) mem_m[i][y*8 +: 8] = wq[k][y*8 +: 8];
                known_m[i] = known_m[i] || (mq[k] == 4'd0);
            end
        end
        if (p) open_m[b] = 1'b0;
    endtask

    task automatic m_read(input logic [20:0] a, input int len, input logic p);
        int b, c, i;
        b = int'(a[20:19]);
        c = int'(a[7:0]);
        exv.delete();
        exk.delete();
        for (int k = 0; k <= len; k++) begin
            if (!open_m[b]) begin
                exv.push_back(32'd0);
                exk.push_back(1'b1);
            end else begin
                i = midx(b, row_m[b], c + k);
                exv.push_back(mem_m[i]);
                exk.push_back(known_m[i]);
            end
        end
        if (!open_m[b]) err_m = 1'b1;
        if (p) open_m[b] = 1'b0;
    endtask

    task automatic m_reset();
        for (int b = 0; b < 4; b++) open_m[b] = 1'b0;
        err_m = 1'b0;
    endtask

    // Issue one command, feed write words, collect read words and the ack edge offset
    task automatic run_cmd(input logic [2:0] c, input logic [20:0] a, input int len, input logic p,
                           input int busy_at);
        rq.delete();
        lat = -1;
        cmd_en = 1'b1; cmd = c; addr = a; dlen = 8'(len); pc = p; wdat = wq[0]; dqm = mq[0];
        @(posedge clk); #1;
        cmd_en = 1'b0;
        ack_at_e = ack;
        for (int j = 1; j <= 600 && lat < 0; j++) begin
            if (j <= len) begin wdat = wq[j]; dqm = mq[j]; end
            else begin wdat = 32'd0; dqm = 4'd0; end
            if (j == busy_at) begin cmd_en = 1'b1; cmd = C_REF; end
            @(posedge clk); #1;
            cmd_en = 1'b0;
            if (c == C_RD && j >= READ_LAT && j <= READ_LAT + len) rq.push_back(rdata);
            if (ack) lat = j;
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL cmd_timeout cmd=%b got=no_ack exp=ack", c);
        end
    endtask

    task automatic do_reset();
        int got;
        got = 0;
        cmd_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int j = 1; j <= 100 && got == 0; j++) begin
            @(posedge clk); #1;
            if (init_done) got = 1;
        end
        if (got == 0) begin
            checks++; failures++;
            $display("FAIL init_timeout got=0 exp=1");
        end
        m_reset();
    endtask

    task automatic test_reset();
        int li;
        bit seen_ack, seen_err;
        li = -1; seen_ack = 1'b0; seen_err = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdata !== 32'd0)  begin failures++; $display("FAIL rst_data got=%h exp=0", rdata); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init got=%b exp=0", init_done); end
        checks++; if (ack !== 1'b0)     begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
        checks++; if (perr !== 1'b0)    begin failures++; $display("FAIL rst_err got=%b exp=0", perr); end
        rst_n = 1'b1;
        for (int j = 1; j <= 100 && li < 0; j++) begin
            if (j == 4) begin cmd_en = 1'b1; cmd = C_REF; end
            @(posedge clk); #1;
            cmd_en = 1'b0;
            if (ack) seen_ack = 1'b1;
            if (perr) seen_err = 1'b1;
            if (init_done) li = j;
        end
        checks++; if (li != INIT_CYCLES) begin failures++; $display("FAIL init_lat got=%0d exp=%0d", li, INIT_CYCLES); end
        checks++; if (seen_ack)  begin failures++; $display("FAIL init_cmd_ack got=1 exp=0"); end
        checks++; if (seen_err)  begin failures++; $display("FAIL init_cmd_err got=1 exp=0"); end
        m_reset();
    endtask

    task automatic test_write_read();
        logic [31:0] pat [8];
        pat = '{32'h12345678, 32'habcdef01, 32'h56781010, 32'habcdeffe,
                32'habceef01, 32'habcdef02, 32'habcdef03, 32'habcdef04};
        run_cmd(C_REF, 21'd0, 0, 1'b0, 0);
        checks++; if (lat != TRFC) begin failures++; $display("FAIL ref_lat got=%0d exp=%0d", lat, TRFC); end
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        checks++; if (lat != ACT_LAT) begin failures++; $display("FAIL act_lat got=%0d exp=%0d", lat, ACT_LAT); end
        checks++; if (ack_at_e !== 1'b0) begin failures++; $display("FAIL ack_clear got=%b exp=0", ack_at_e); end
        for (int k = 0; k < 8; k++) begin wq[k] = pat[k]; mq[k] = 4'd0; end
        run_cmd(C_WR, 21'd0, 7, 1'b1, 0);
        m_write(21'd0, 7, 1'b1);
        checks++; if (lat != 7 + WRITE_REC) begin failures++; $display("FAIL wr_lat got=%0d exp=%0d", lat, 7 + WRITE_REC); end
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        run_cmd(C_RD, 21'd0, 7, 1'b1, 0);
        m_read(21'd0, 7, 1'b1);
        checks++; if (lat != READ_LAT + 7) begin failures++; $display("FAIL rd_lat got=%0d exp=%0d", lat, READ_LAT + 7); end
        checks++; if (rq[0] !== 32'h12345678) begin failures++; $display("FAIL rd_first got=%h exp=12345678", rq[0]); end
        checks++; if (rq[7] !== 32'habcdef04) begin failures++; $display("FAIL rd_last got=%h exp=abcdef04", rq[7]); end
        for (int k = 1; k < 7; k++) begin
            checks++;
            if (rq[k] !== exv[k]) begin failures++; $display("FAIL rd_word%0d got=%h exp=%h", k, rq[k], exv[k]); end
        end
        checks++; if (rdata !== 32'habcdef04) begin failures++; $display("FAIL rd_hold got=%h exp=abcdef04", rdata); end
        checks++; if (perr !== err_m) begin failures++; $display("FAIL wr_rd_err got=%b exp=%b", perr, err_m); end
    endtask

    task automatic test_row_ignored();
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        run_cmd(C_RD, 21'h000101, 0, 1'b1, 0);
        m_read(21'h000101, 0, 1'b1);
        checks++; if (rq[0] !== 32'habcdef01) begin failures++; $display("FAIL row_ignored got=%h exp=abcdef01", rq[0]); end
    endtask

    task automatic test_dqm();
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        wq[0] = 32'h11223344; mq[0] = 4'b0000;
        run_cmd(C_WR, 21'h000020, 0, 1'b0, 0);
        m_write(21'h000020, 0, 1'b0);
        wq[0] = 32'haabbccdd; mq[0] = 4'b0101;
        run_cmd(C_WR, 21'h000020, 0, 1'b1, 0);
        m_write(21'h000020, 0, 1'b1);
        checks++; if (lat != WRITE_REC) begin failures++; $display("FAIL wr0_lat got=%0d exp=%0d", lat, WRITE_REC); end
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        run_cmd(C_RD, 21'h000020, 0, 1'b1, 0);
        m_read(21'h000020, 0, 1'b1);
        checks++; if (rq[0] !== 32'haa22cc44) begin failures++; $display("FAIL dqm_merge got=%h exp=aa22cc44", rq[0]); end
        mq[0] = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [31:0] sv [4];
        for (int k = 0; k < 4; k++) begin sv[k] = $urandom; wq[k] = sv[k]; mq[k] = 4'd0; end
        run_cmd(C_ACT, 21'h000100, 0, 1'b0, 0);
        m_act(21'h000100);
        run_cmd(C_WR, 21'h0001FE, 3, 1'b1, 0);
        m_write(21'h0001FE, 3, 1'b1);
        run_cmd(C_ACT, 21'h000100, 0, 1'b0, 0);
        m_act(21'h000100);
        run_cmd(C_RD, 21'h0001FE, 3, 1'b1, 0);
        m_read(21'h0001FE, 3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rq[k] !== sv[k]) begin failures++; $display("FAIL wrap_word%0d got=%h exp=%h", k, rq[k], sv[k]); end
        end
        run_cmd(C_ACT, 21'h000100, 0, 1'b0, 0);
        m_act(21'h000100);
        run_cmd(C_RD, 21'h000100, 1, 1'b1, 0);
        m_read(21'h000100, 1, 1'b1);
        checks++; if (rq[0] !== sv[2]) begin failures++; $display("FAIL wrap_col00 got=%h exp=%h", rq[0], sv[2]); end
        checks++; if (rq[1] !== sv[3]) begin failures++; $display("FAIL wrap_col01 got=%h exp=%h", rq[1], sv[3]); end
    endtask

    task automatic test_random();
        logic [20:0] a, ra;
        int len, rlen;
        for (int it = 0; it < 7; it++) begin
            a = 21'($urandom);
            len = (it == 6) ? 255 : int'($urandom_range(0, 15));
            for (int k = 0; k <= len; k++) begin wq[k] = $urandom; mq[k] = 4'($urandom_range(0, 3) == 0 ? $urandom : 0); end
            run_cmd(C_ACT, a, 0, 1'b0, 0);
            m_act(a);
            run_cmd(C_WR, a, len, 1'b1, 0);
            m_write(a, len, 1'b1);
            checks++; if (lat != len + WRITE_REC) begin failures++; $display("FAIL rnd_wr_lat got=%0d exp=%0d", lat, len + WRITE_REC); end
            ra = {a[20:8], 8'(a[7:0] + 8'($urandom_range(0, 7)))};
            rlen = (it == 6) ? 255 : int'($urandom_range(0, 15));
            run_cmd(C_ACT, a, 0, 1'b0, 0);
            m_act(a);
            run_cmd(C_RD, ra, rlen, 1'b1, 0);
            m_read(ra, rlen, 1'b1);
            checks++; if (lat != READ_LAT + rlen) begin failures++; $display("FAIL rnd_rd_lat got=%0d exp=%0d", lat, READ_LAT + rlen); end
            for (int k = 0; k <= rlen; k++) begin
                if (exk[k]) begin
                    checks++;
                    if (rq[k] !== exv[k]) begin failures++; $display("FAIL rnd_word it=%0d k=%0d got=%h exp=%h", it, k, rq[k], exv[k]); end
                end
            end
        end
        for (int k = 0; k < 256; k++) mq[k] = 4'd0;
        checks++; if (perr !== err_m) begin failures++; $display("FAIL rnd_err got=%b exp=%b", perr, err_m); end
    endtask

    task automatic test_violations();
        logic [20:0] a;
        // read from a closed bank with auto-precharge
        do_reset();
        a = 21'($urandom);
        run_cmd(C_RD, a, 2, 1'b1, 0);
        m_read(a, 2, 1'b1);
        checks++; if (lat != READ_LAT + 2) begin failures++; $display("FAIL closed_rd_lat got=%0d exp=%0d", lat, READ_LAT + 2); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rq[k] !== exv[k]) begin failures++; $display("FAIL closed_rd_word%0d got=%h exp=%h", k, rq[k], exv[k]); end
        end
        checks++; if (perr !== err_m) begin failures++; $display("FAIL closed_rd_err got=%b exp=%b", perr, err_m); end
        // cmd_en on the ack edge counts as busy
        do_reset();
        run_cmd(C_REF, 21'd0, 0, 1'b0, TRFC);
        err_m = 1'b1;
        checks++; if (lat != TRFC) begin failures++; $display("FAIL busy_ref_lat got=%0d exp=%0d", lat, TRFC); end
        checks++; if (perr !== err_m) begin failures++; $display("FAIL busy_err got=%b exp=%b", perr, err_m); end
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        checks++; if (lat != ACT_LAT) begin failures++; $display("FAIL busy_next_lat got=%0d exp=%0d", lat, ACT_LAT); end
        run_cmd(C_PRE, 21'd0, 0, 1'b0, 0);
        checks++; if (lat != 1) begin failures++; $display("FAIL pre_lat got=%0d exp=1", lat); end
        // undefined command code
        do_reset();
        cmd_en = 1'b1; cmd = 3'b111;
        @(posedge clk); #1;
        cmd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (perr !== 1'b1) begin failures++; $display("FAIL undef_err got=%b exp=1", perr); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL undef_ack got=%b exp=0", ack); end
        // async reset in the middle of a read burst
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        cmd_en = 1'b1; cmd = C_RD; addr = 21'd0; dlen = 8'd7; pc = 1'b1;
        @(posedge clk); #1;
        cmd_en = 1'b0;
        repeat (READ_LAT + 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (rdata !== 32'd0)   begin failures++; $display("FAIL midrst_data got=%h exp=0", rdata); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL midrst_init got=%b exp=0", init_done); end
        checks++; if (ack !== 1'b0)      begin failures++; $display("FAIL midrst_ack got=%b exp=0", ack); end
        checks++; if (perr !== 1'b0)     begin failures++; $display("FAIL midrst_err got=%b exp=0", perr); end
        do_reset();
        run_cmd(C_ACT, 21'd0, 0, 1'b0, 0);
        m_act(21'd0);
        run_cmd(C_RD, 21'd0, 0, 1'b1, 0);
        m_read(21'd0, 0, 1'b1);
        checks++; if (rq[0] !== 32'h12345678) begin failures++; $display("FAIL ram_kept got=%h exp=12345678", rq[0]); end
        checks++; if (perr !== err_m) begin failures++; $display("FAIL post_rst_err got=%b exp=%b", perr, err_m); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin wq[k] = 32'd0; mq[k] = 4'd0; end
        test_reset();
        test_write_read();
        test_row_ignored();
        test_dqm();
        test_wrap();
        test_random();
        test_violations();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdrc_responder_model.md
Name: sdrc_responder_model

Overview:
- Synthesizable stand-in for the vendor SDRAM controller's user-side interface. It is the responder to the cache/testbench initiator.
- It accepts the same I_sdrc_cmd_en/I_sdrc_cmd/I_sdrc_addr/I_sdrc_data/I_sdrc_data_len handshake and answers with O_sdrc_init_done, O_sdrc_cmd_ack and O_sdrc_data.
- Storage is an internal word RAM, not external SDRAM.
- Used for fast cache regression and for FPGA bring-up without the SDRAM. Also flags protocol misuse by the initiator.

Parameters:
- ADDR_WIDTH, 12, log2 of backing RAM words; index = low ADDR_WIDTH bits of {bank, row, col}.
- INIT_CYCLES, 16, cycles after reset release until O_sdrc_init_done.
- ACT_LAT, 1, edges after ACTIVE acceptance until ack.
- READ_LAT, 4, edges from READ acceptance to first data word.
- WRITE_REC, 3, edges after last write word until ack.
- TRFC, 9, edges after REFRESH acceptance until ack.

Ports:
- I_sdrc_clk  in  1  single clock.
- I_sdrc_rst_n  in  1  reset, asynchronous and active-low.
- I_sdrc_cmd_en  in  1  command strobe, one cycle.
- I_sdrc_cmd  in  3  001 refresh, 010 precharge-all, 011 active, 100 write, 101 read.
- I_sdrc_precharge_ctrl  in  1  1 = auto-precharge (close bank) after read/write.
- I_sdrc_addr  in  21  {bank[20:19], row[18:8], col[7:0]}.
- I_sdrc_dqm  in  4  byte mask for writes; 1 = byte not written.
- I_sdrc_data  in  32  write data.
- I_sdrc_data_len  in  8  burst length minus 1.
- O_sdrc_data  out  32  read data.
- O_sdrc_init_done  out  1  initialization complete, sticky.
- O_sdrc_cmd_ack  out  1  command complete.
- O_proto_err  out  1  sticky protocol-violation flag.

Behaviour:
Reset (async, any time, including mid-burst):
- States go to INIT; init counter clears.
- O_sdrc_data=0, O_sdrc_init_done=0, O_sdrc_cmd_ack=0, O_proto_err=0.
- All banks are closed. RAM contents are not cleared.

State machine: INIT, IDLE, ACT, WR, RD, REF, PRE.
- INIT: counts INIT_CYCLES edges, then sets init_done and goes to IDLE. cmd_en in INIT is ignored, no error.
- IDLE: cmd_en sampled high at edge E accepts the command. The ack level clears at E. Undefined cmd codes (000, 110, 111) are ignored and set O_proto_err.
- ACT: latches row[bank]=addr row and marks bank open. ack rises at E+ACT_LAT. Activating an already-open bank sets O_proto_err and overwrites the row.
- WR:
  - Word k (k=0..len) is captured at edge E+k; word 0 is presented together with cmd_en.
  - Target address = {addr bank, open row of that bank, (col+k) mod 256}. Column wraps within the row.
  - Each byte is written only if its dqm bit is 0. dqm is sampled per word.
  - ack rises at E+len+WRITE_REC.
- RD:
  - O_sdrc_data updates at edge E+READ_LAT+k with word (col+k) mod 256 of the open row.
  - The last word is held until the next read.
  - ack rises at the same edge as the last word.
- Address source for WR/RD: row bits of I_sdrc_addr are ignored; only the bank's activated row is used.
- WR/RD to a closed bank: sets O_proto_err; writes are suppressed, reads return 0; timing is unchanged.
- Auto-precharge: if precharge_ctrl=1, the accessed bank closes when ack rises.
- REF: ack at E+TRFC.
- PRE: closes all banks; ack at E+1.
- ack: once risen, holds high until the next accepted cmd_en. Return to IDLE at the ack edge.
- cmd_en while not in IDLE (busy): ignored and sets O_proto_err. This includes cmd_en on the same edge ack rises; the earliest accept is one edge later.
- Burst length: data_len=255 gives 256 words and a full row wrap.
- Overlap: read/write within one burst never overlap, so no bypass is needed.

Test Plan:
- Reset release -> O_sdrc_init_done rises exactly INIT_CYCLES edges later. A cmd_en issued earlier gets no ack and no O_proto_err.
- Refresh, then ACTIVE addr 0, then WRITE len 7 of 12345678, abcdef01, 56781010, abcdeffe, abceef01, abcdef02, abcdef03, abcdef04 -> ack at E+ACT_LAT after ACTIVE and at E+10 after WRITE. ACTIVE 0 then READ len 7 -> word 0 = 12345678 at E+4, abcdef04 at E+11, ack with last word.
- ACTIVE 0x000, READ addr 0x101 len 0 -> abcdef01; the row field of the read address is ignored.
- WRITE len 0, dqm=4'b0101, data aabbccdd over word 11223344 -> readback aa22cc44.
- ACTIVE row 1 col 0xFE, WRITE len 3 -> cols FE, FF, 00, 01 written; readback confirms the wrap.
- Violations: READ with precharge_ctrl=1 and no intervening ACTIVE, cmd_en while busy, cmd 111 -> O_proto_err=1 and stays set. Async reset mid-read -> all outputs 0 immediately and O_proto_err cleared.
